button_router: RTL
==================

// Module: button_router
// PURPOSE
//  Parametrised successor to the fixed 3-button shaper + decoder front end.
//  - Conditions N_BTN raw active-low push buttons: 2-FF sync, debounce,
//    one-shot on press, optional auto-repeat while held.
//  - Routes each pulse to one of N_DEST consumers: process control, access
//    control, game and scoreboard, selected by process control via dest_sel.
// PARAMETERS
//  N_BTN          3    number of button channels
//  N_DEST         4    number of destination pulse vectors
//  SEL_W          2    dest_sel width; N_DEST <= 2**SEL_W required
//  DB_CYCLES      4    consecutive stable cycles before the debounced level changes (>=1)
//  DB_W           16   debounce counter width; DB_CYCLES < 2**DB_W
//  REPEAT_CYCLES  0    auto-repeat period in cycles while held; 0 = repeat disabled
//  RPT_W          24   repeat counter width; REPEAT_CYCLES < 2**RPT_W
// PORTS
//  clk        in   1             system clock; all state on rising edge
//  rst        in   1             synchronous, active-high reset
//  btn_n      in   N_BTN         raw buttons, active-low (0 = pressed), asynchronous
//  dest_sel   in   SEL_W         destination index for pulses
//  pulse_out  out  N_BTN*N_DEST  one-cycle press pulses; dest d in bits [d*N_BTN +: N_BTN]
//  btn_level  out  N_BTN         debounced level, 1 = pressed
//  sel_err    out  1             registered: dest_sel >= N_DEST in the previous cycle
// BEHAVIOUR
//  Reset, sampled at the clk edge while rst=1:
//   - sync FFs = released, btn_level = 0, all counters = 0, pulse_out = 0,
//     sel_err = 0, all channel FSMs = IDLE.
//   - Reset mid-debounce or mid-repeat discards the pending event.
//   - A button held through reset is a new press after the full latency.
//  Sync:
//   - s1 <= ~btn_n, then s2 <= s1. Channels are fully independent.
//  Debounce, per channel:
//   - If s2 == btn_level, cnt <= 0.
//   - Else if cnt == DB_CYCLES-1, btn_level toggles and cnt <= 0.
//   - Else cnt increments.
//   - Glitches shorter than DB_CYCLES cycles never change btn_level.
//  Channel FSM:
//   - IDLE: btn_level rises -> fire, go to HELD, rpt <= 0.
//   - HELD: btn_level falls -> IDLE, rpt <= 0, no pulse on release.
//   - HELD with REPEAT_CYCLES>0: rpt increments; at REPEAT_CYCLES-1 -> fire, rpt <= 0.
//   - HELD with REPEAT_CYCLES=0: rpt stays 0, no further pulses.
//   - Release in the same cycle as a repeat fire: release wins, no pulse.
//  Routing, registered:
//   - Fire in cycle t: pulse_out[dest_sel*N_BTN + b] = 1 for exactly cycle t+1,
//     using dest_sel sampled in cycle t.
//   - All other pulse_out bits are 0.
//   - If dest_sel >= N_DEST, the pulse is dropped. sel_err mirrors this
//     condition 1 cycle late, whether or not a pulse fired.
//  Latency:
//   - Press sampled at edge 0 -> btn_level = 1 after edge DB_CYCLES+1
//     -> pulse_out high after edge DB_CYCLES+2, for 1 cycle.
//   - Release has the same debounce latency and produces no pulse.
//  Simultaneous presses on several channels give simultaneous pulses to the
//  same destination.
// TESTING
//  T1 DB=4, sel=0, hold btn_n[0]=0 from edge 0: btn_level[0]=1 after edge 5;
//     pulse_out[0]=1 only in the cycle after edge 6; no further pulses while held.
//  T2 3-cycle low glitch on btn_n[1]: btn_level and pulse_out stay 0.
//     A 4-cycle low produces one pulse.
//  T3 sel=2, press btn 2 -> only pulse_out[8]=1. Set sel=3 and press btn 0
//     -> only pulse_out[9]=1.
//  T4 N_DEST=3, sel=3: press btn -> pulse_out all 0, sel_err=1.
//     Set sel=1 -> sel_err=0 one cycle later.
//  T5 REPEAT_CYCLES=10, hold btn 0 for 35 cycles after the first pulse:
//     pulses at +0, +10, +20, +30. Release -> no more pulses.
//  T6 rst=1 for 1 cycle during debounce and during repeat: all outputs 0
//     next cycle; a button still held re-pulses after DB_CYCLES+2 edges.

Source files
------------

// File: rtl/button_router.sv
// button_router: N_BTN active-low buttons -> sync, debounce, one-shot/auto-repeat, routed to N_DEST pulse vectors.
// Latency: press sampled at edge 0 -> btn_level after edge DB_CYCLES+1 -> pulse_out after edge DB_CYCLES+2.
// Backpressure: none; consumers must accept single-cycle pulses whenever they appear.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst        synchronous active-high reset
//   btn_n      raw asynchronous buttons, 0 = pressed
//   dest_sel   destination index for pulses fired this cycle
//   pulse_out  one-cycle press pulses; destination d occupies [d*N_BTN +: N_BTN]
//   btn_level  debounced button level, 1 = pressed
//   sel_err    dest_sel was out of range in the previous cycle
module button_router #(
  parameter int N_BTN         = 3,
  parameter int N_DEST        = 4,
  parameter int SEL_W         = 2,
  parameter int DB_CYCLES     = 4,
  parameter int DB_W          = 16,
  parameter int REPEAT_CYCLES = 0,
  parameter int RPT_W         = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_BTN-1:0]        btn_n,
  input  logic [SEL_W-1:0]        dest_sel,
  output logic [N_BTN*N_DEST-1:0] pulse_out,
  output logic [N_BTN-1:0]        btn_level,
  output logic                    sel_err
);

  typedef enum logic {
    ST_IDLE,
    ST_HELD
  } state_e;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
  // Only meaningful when auto-repeat is enabled; clamped so the constant stays non-negative.
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  logic [N_BTN-1:0]        sync1_q, sync2_q;
  logic [N_BTN-1:0]        level_q, level_d;
  logic [DB_W-1:0]         db_cnt_q [N_BTN];
  logic [DB_W-1:0]         db_cnt_d [N_BTN];
  logic [RPT_W-1:0]        rpt_q    [N_BTN];
  logic [RPT_W-1:0]        rpt_d    [N_BTN];
  state_e                  state_q  [N_BTN];
  state_e                  state_d  [N_BTN];
  logic [N_BTN-1:0]        fire;
  logic [N_BTN*N_DEST-1:0] pulse_q, pulse_d;
  logic                    sel_err_q, sel_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      pulse_q   <= '0;
      sel_err_q <= 1'b0;
      for (int b = 0; b < N_BTN; b++) begin
        db_cnt_q[b] <= '0;
        rpt_q[b]    <= '0;
        state_q[b]  <= ST_IDLE;
      end
    end else begin
      sync1_q   <= ~btn_n;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      pulse_q   <= pulse_d;
      sel_err_q <= sel_err_d;
      for (int b = 0; b < N_BTN; b++) begin
        db_cnt_q[b] <= db_cnt_d[b];
        rpt_q[b]    <= rpt_d[b];
        state_q[b]  <= state_d[b];
      end
    end
  end

  // Debounce: the level only flips after DB_CYCLES consecutive disagreeing samples.
  always_comb begin
    for (int b = 0; b < N_BTN; b++) begin
      level_d[b]  = level_q[b];
      db_cnt_d[b] = '0;
      if (sync2_q[b] != level_q[b]) begin
        if (db_cnt_q[b] == DB_LAST) begin
          level_d[b] = ~level_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
        end
      end
    end
  end

  // Channel FSM: fire on the debounced rising edge, then optionally every
  // REPEAT_CYCLES while held. Release is checked first so it beats a repeat.
  always_comb begin
    for (int b = 0; b < N_BTN; b++) begin
      state_d[b] = state_q[b];
      rpt_d[b]   = rpt_q[b];
      fire[b]    = 1'b0;
      case (state_q[b])
        ST_IDLE: begin
          if (level_q[b]) begin
            fire[b]    = 1'b1;
            state_d[b] = ST_HELD;
            rpt_d[b]   = '0;
          end
        end
        ST_HELD: begin
          if (!level_q[b]) begin
            state_d[b] = ST_IDLE;
            rpt_d[b]   = '0;
          end else if (REPEAT_CYCLES > 0) begin
            if (rpt_q[b] == RPT_LAST) begin
              fire[b]  = 1'b1;
              rpt_d[b] = '0;
            end else begin
              rpt_d[b] = rpt_q[b] + RPT_W'(1);
            end
          end
        end
        default: begin
          state_d[b] = ST_IDLE;
          rpt_d[b]   = '0;
        end
      endcase
    end
  end

  // Routing: only the selected destination slice sees this cycle's fires;
  // an out-of-range selector matches no slice, so the pulse is dropped.
  always_comb begin
    pulse_d   = '0;
    sel_err_d = (int'(dest_sel) >= N_DEST);
    for (int d = 0; d < N_DEST; d++) begin
      if (int'(dest_sel) == d) begin
        pulse_d[d*N_BTN +: N_BTN] = fire;
      end
    end
  end

  assign pulse_out = pulse_q;
  assign btn_level = level_q;
  assign sel_err   = sel_err_q;

endmodule
